// File: rtl/time_entry_writer_pkg.sv
// rtl/time_entry_writer_pkg.sv - shared types, limits and helpers for keypad time entry
package time_entry_writer_pkg;

  localparam int DIGITS = 6;
  localparam logic [3:0] H10_MAX = 4'd2;
  localparam int HOUR_MAX = 23;
  localparam logic [3:0] MS10_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Largest digit accepted at a cursor position (0 = H10).
  function automatic bcd_t digit_limit(input logic [2:0] pos);
    case (pos)
      3'd0:       digit_limit = H10_MAX;
      3'd2, 3'd4: digit_limit = MS10_MAX;
      default:    digit_limit = DIGIT_MAX;
    endcase
  endfunction

  function automatic logic hour_ok(input bcd_t h10, input bcd_t h1);
    logic [7:0] hh;
    hh = {4'd0, h10} * 8'd10 + {4'd0, h1};
    return hh <= 8'(HOUR_MAX);
  endfunction

endpackage

// File: rtl/time_entry_writer_onehot10_to_bcd.sv
// rtl/time_entry_writer_onehot10_to_bcd.sv - one-hot keypad pulse to BCD digit decoder
module onehot10_to_bcd
  import time_entry_writer_pkg::*;
(
  input  logic [9:0] i_onehot,
  output bcd_t       o_digit,
  output logic       o_valid
);

  always_comb begin
    o_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (i_onehot[i]) o_digit = 4'(i);
    end
  end

  // Nonzero with no second bit set.
  assign o_valid = (i_onehot != 10'd0) && ((i_onehot & (i_onehot - 10'd1)) == 10'd0);

endmodule

// File: rtl/time_entry_writer.sv
// rtl/time_entry_writer.sv - collects six BCD keypad digits, validates HH, issues one time write
module time_entry_writer
  import time_entry_writer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 30_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [9:0]  keypad,
  input  logic        sharp,
  output logic [23:0] set_time,
  output logic        write,
  output logic        complete,
  output logic        error,
  output logic [2:0]  cursor,
  output logic        h,
  output logic        m,
  output logic        s
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 25) ? $clog2(TIMEOUT_CYCLES + 1) : 25;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  r_state, w_state;
  bcd_t [DIGITS-1:0]       r_buf, w_buf;
  logic [2:0]              r_cursor, w_cursor;
  logic [CNT_W-1:0]        r_cnt, w_cnt;
  logic [23:0]             r_set_time, w_set_time;
  logic                    r_write, w_write;
  logic                    r_complete, w_complete;
  logic                    r_error, w_error;
  logic                    r_h, r_m, r_s, w_h, w_m, w_s;
  bcd_t                    w_key_digit;
  logic                    w_key_valid;

  onehot10_to_bcd u_dec (
    .i_onehot (keypad),
    .o_digit  (w_key_digit),
    .o_valid  (w_key_valid)
  );

  always_comb begin
    w_state    = r_state;
    w_buf      = r_buf;
    w_cursor   = r_cursor;
    w_cnt      = r_cnt;
    w_set_time = r_set_time;
    w_write    = 1'b0;
    w_complete = 1'b0;
    w_error    = 1'b0;
    if (!en) begin
      w_state  = ST_IDLE;
      w_buf    = '0;
      w_cursor = 3'd0;
      w_cnt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state  = ST_ENTRY;
          w_buf    = '0;
          w_cursor = 3'd0;
          w_cnt    = '0;
        end
        ST_ENTRY: begin
          // Confirm takes priority over a key arriving in the same cycle.
          if (sharp) begin
            w_state = ST_CHECK;
          end else if (w_key_valid) begin
            w_cnt = '0;
            if (w_key_digit <= digit_limit(r_cursor)) begin
              w_buf[r_cursor] = w_key_digit;
              w_cursor = (r_cursor == 3'(DIGITS - 1)) ? 3'd0 : r_cursor + 3'd1;
            end else begin
              w_error = 1'b1;
            end
          end else if (r_cnt == CNT_LAST) begin
            w_error  = 1'b1;
            w_buf    = '0;
            w_cursor = 3'd0;
            w_cnt    = '0;
          end else if (r_cnt != '1) begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (hour_ok(r_buf[0], r_buf[1])) begin
            w_set_time = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4], r_buf[5]};
            w_write    = 1'b1;
            w_state    = ST_COMMIT;
          end else begin
            w_error  = 1'b1;
            w_cursor = 3'd0;
            w_cnt    = '0;
            w_state  = ST_ENTRY;
          end
        end
        ST_COMMIT: begin
          w_complete = 1'b1;
          w_state    = ST_DONE;
        end
        ST_DONE: begin
          w_state = ST_DONE;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
    w_h = (w_state == ST_ENTRY) && (w_cursor <= 3'd1);
    w_m = (w_state == ST_ENTRY) && ((w_cursor == 3'd2) || (w_cursor == 3'd3));
    w_s = (w_state == ST_ENTRY) && ((w_cursor == 3'd4) || (w_cursor == 3'd5));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_cursor   <= 3'd0;
      r_cnt      <= '0;
      r_set_time <= 24'd0;
      r_write    <= 1'b0;
      r_complete <= 1'b0;
      r_error    <= 1'b0;
      r_h        <= 1'b0;
      r_m        <= 1'b0;
      r_s        <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_buf      <= w_buf;
      r_cursor   <= w_cursor;
      r_cnt      <= w_cnt;
      r_set_time <= w_set_time;
      r_write    <= w_write;
      r_complete <= w_complete;
      r_error    <= w_error;
      r_h        <= w_h;
      r_m        <= w_m;
      r_s        <= w_s;
    end
  end

  assign set_time = r_set_time;
  assign write    = r_write;
  assign complete = r_complete;
  assign error    = r_error;
  assign cursor   = r_cursor;
  assign h        = r_h;
  assign m        = r_m;
  assign s        = r_s;

endmodule

// File: doc/time_entry_writer.md
# time_entry_writer

Keypad-driven time entry block: collects six BCD digits (HHMMSS) from keypad key pulses, validates them, and issues a single write transaction of `set_time`/`write` to the time register's write port. It sits between the keypad level-to-pulse converter and the time register, feeding the same set/write interface as the shortcut and manual setting paths. It also drives h/m/s field indicators for display blinking and reports completion to the main state machine.

## Interface
- `TIMEOUT_CYCLES`, default 30_000_000: idle cycles in entry before abort.
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `en`  in  1: block enable from the main state machine; level.
- `keypad`  in  10: one-cycle key pulses; bit i = digit i.
- `sharp`  in  1: one-cycle confirm pulse.
- `set_time`  out  24: BCD {H10,H1,M10,M1,S10,S1}, [23:20]=H10.
- `write`  out  1: one-cycle write strobe to the time register.
- `complete`  out  1: one-cycle pulse, entry committed.
- `error`  out  1: one-cycle pulse, key rejected, validation failure or timeout.
- `cursor`  out  3: current digit index 0..5, 0=H10.
- `h`, `m`, `s`  out  1 each: active field indicator.

## Operation
- States: IDLE, ENTRY, CHECK, COMMIT, DONE.
- IDLE: buffer=0, cursor=0, h/m/s=0. `en`=1 → ENTRY.
- ENTRY: a key is valid only if exactly one `keypad` bit is set. Zero or multi-bit patterns are ignored with no error.
  - Position limits: H10≤2, M10≤5, S10≤5, others ≤9.
  - Key within limit: buffer[cursor]←digit, cursor←cursor+1, wrapping from 5 to 0.
  - Key over limit: `error` pulse; buffer and cursor unchanged.
- `sharp` in ENTRY → CHECK. If `sharp` and a key arrive in the same cycle, `sharp` wins and the key is dropped.
- CHECK:
  - HH≤23: `set_time`←buffer, → COMMIT.
  - HH>23: `error` pulse, cursor←0, buffer kept, → ENTRY.
- COMMIT: `write`=1 for exactly one cycle, → DONE.
- DONE: `complete`=1 on the first DONE cycle only. Hold until `en`=0.
- Timeout: idle counter cleared on every accepted/rejected key and on entry into ENTRY. Reaching TIMEOUT_CYCLES in ENTRY → `error` pulse, buffer=0, cursor=0, stay ENTRY.
- `en`=0 in any state → IDLE next cycle. No `write` is issued, even from CHECK or COMMIT.
- Field indicators: in ENTRY, h=1 when cursor∈{0,1}, m=1 when cursor∈{2,3}, s=1 when cursor∈{4,5}. All 0 in other states.
- `set_time` changes only in CHECK, so it is stable whenever `write`=1.

## Timing
- Reset: state=IDLE; `set_time`=0, `write`=0, `complete`=0, `error`=0, `cursor`=0, h/m/s=0. Registers are cleared mid-operation with no pending write.
- All outputs are registered.
- Key sampled at edge N → buffer/cursor updated after N; `error` for a rejected key is high for the cycle after N.
- `sharp` sampled at edge N:
  - CHECK during cycle N+1.
  - `write` high during cycle N+2, with `set_time` valid from N+2.
  - `complete` high during cycle N+3.
- Keys arriving during CHECK, COMMIT or DONE are ignored.
- The timeout counter is ≥25 bits wide, saturating, and counts only in ENTRY.

## Structure
- Shared package holds:
  - state enum.
  - `DIGITS`=6.
  - field limits (`H10_MAX`=2, `HOUR_MAX`=23, `MS10_MAX`=5).
  - BCD nibble typedef.
- One sub-module, `onehot10_to_bcd`: outputs 4-bit digit plus `valid` (exactly one bit set). Combinational, instantiated once.
- Buffer, cursor, timeout counter and FSM live in the top of this block.

## Test plan
- `en`=1; keys 1,2,3,4,5,6; `sharp` → `write` 2 cycles after `sharp` with `set_time`=0x123456; `complete` the following cycle; `cursor` 0 after wrap.
- Keys 2,5 at cursor 0–1, then `sharp` → `error` pulse 1 cycle after CHECK; no `write`; `cursor`=0; buffer H=25 retained.
- Key 7 at cursor 0, and key 6 at cursor 2 → `error` each time; cursor unchanged; buffer unchanged.
- `keypad`=0b0000000011 (two bits) → ignored, no `error`. `sharp` and key 3 in the same cycle → CHECK entered, digit not written.
- `TIMEOUT_CYCLES`=16, after one key idle 16 cycles → `error`, buffer 0, cursor 0. Separately, `en` dropped in CHECK → IDLE, `write` never asserted.
- Assert `reset`=0 asynchronously mid-entry with cursor=3 → all outputs 0 immediately; after release and `en`=1, entry restarts at cursor 0.
